// File: rtl/pll_lock_ctrl.sv
// Reset/lock sequencer for the core PLL: pulses the PLL reset, qualifies lock,
// retries on timeout and publishes a registered pll_ready level.
module pll_lock_ctrl #(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES    = 3,
    parameter int CNT_W          = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             locked,
    input  logic             restart_req,
    output logic             pll_rst,
    output logic             pll_ready,
    output logic             pll_fail,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int MAX_RS  = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_RS > TIMEOUT_CYCLES) ? MAX_RS : TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC) + 1;

    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETRY_LIMIT  = CNT_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    // Every input, reset included, is captured once before the FSM acts on it,
    // so each one takes effect on the edge after it is sampled.
    logic             rst_n_reg;
    logic             restart_reg;
    logic [1:0]       sync_reg;
    logic             lock_s;

    state_t           state_reg, state_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic [CNT_W-1:0] retry_reg, retry_next;
    logic [CNT_W-1:0] loss_reg, loss_next;
    logic             timer_clr;
    logic             pll_rst_reg, pll_ready_reg, pll_fail_reg;

    assign lock_s = sync_reg[1];

    always_ff @(posedge refclk) begin
        rst_n_reg <= rst_n;
        if (!rst_n_reg) begin
            sync_reg      <= 2'b00;
            restart_reg   <= 1'b0;
            state_reg     <= ST_RESET;
            timer_reg     <= '0;
            retry_reg     <= '0;
            loss_reg      <= '0;
            pll_rst_reg   <= 1'b1;
            pll_ready_reg <= 1'b0;
            pll_fail_reg  <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[0], locked};
            restart_reg   <= restart_req;
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            retry_reg     <= retry_next;
            loss_reg      <= loss_next;
            pll_rst_reg   <= (state_next == ST_RESET) || (state_next == ST_FAIL);
            pll_ready_reg <= (state_next == ST_RUN);
            pll_fail_reg  <= (state_next == ST_FAIL);
        end
    end

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        loss_next  = loss_reg;
        timer_clr  = 1'b0;

        if (restart_reg) begin
            // Restart also rewinds the timer when already in RESET.
            state_next = ST_RESET;
            retry_next = '0;
            timer_clr  = 1'b1;
        end else begin
            case (state_reg)
                ST_RESET: begin
                    if (timer_reg == RST_LAST)
                        state_next = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_next = ST_STABLE;
                    end else if (timer_reg == TIMEOUT_LAST) begin
                        if (retry_reg == RETRY_LIMIT) begin
                            state_next = ST_FAIL;
                        end else begin
                            retry_next = retry_reg + 1'b1;
                            state_next = ST_RESET;
                        end
                    end
                end
                ST_STABLE: begin
                    // A drop here is not counted as a loss; lock simply requalifies.
                    if (!lock_s)
                        state_next = ST_WAIT_LOCK;
                    else if (timer_reg == STABLE_LAST)
                        state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        if (loss_reg != '1)
                            loss_next = loss_reg + 1'b1;
                        state_next = ST_RESET;
                    end
                end
                ST_FAIL: begin
                    state_next = ST_FAIL;
                end
                default: begin
                    state_next = ST_RESET;
                end
            endcase
        end

        if ((state_next == ST_RUN) && (state_reg != ST_RUN))
            retry_next = '0;

        if (timer_clr || (state_next != state_reg))
            timer_next = '0;
        else
            timer_next = timer_reg + 1'b1;
    end

    assign pll_rst       = pll_rst_reg;
    assign pll_ready     = pll_ready_reg;
    assign pll_fail      = pll_fail_reg;
    assign state         = state_reg;
    assign retry_cnt     = retry_reg;
    assign lock_loss_cnt = loss_reg;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench for pll_lock_ctrl: expectations are queued with the edge
// at which they must hold and compared right after that edge.
module tb_pll_lock_ctrl;

    localparam int CNT_W = 8;

    localparam int S_STATE = 0;
    localparam int S_RST   = 1;
    localparam int S_READY = 2;
    localparam int S_FAIL  = 3;
    localparam int S_RETRY = 4;
    localparam int S_LOSS  = 5;

    logic             refclk;
    logic             rst_n;
    logic             locked;
    logic             restart_req;
    logic             pll_rst;
    logic             pll_ready;
    logic             pll_fail;
    logic [2:0]       state;
    logic [CNT_W-1:0] retry_cnt;
    logic [CNT_W-1:0] lock_loss_cnt;

    pll_lock_ctrl #(
        .RST_CYCLES     (4),
        .STABLE_CYCLES  (8),
        .TIMEOUT_CYCLES (32),
        .MAX_RETRIES    (2),
        .CNT_W          (CNT_W)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .locked        (locked),
        .restart_req   (restart_req),
        .pll_rst       (pll_rst),
        .pll_ready     (pll_ready),
        .pll_fail      (pll_fail),
        .state         (state),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct {
        int at_edge;
        int sig;
        int val;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic string sig_name(input int sig);
        case (sig)
            S_STATE: return "state";
            S_RST:   return "pll_rst";
            S_READY: return "pll_ready";
            S_FAIL:  return "pll_fail";
            S_RETRY: return "retry_cnt";
            default: return "lock_loss_cnt";
        endcase
    endfunction

    function automatic int sig_value(input int sig);
        case (sig)
            S_STATE: return int'(state);
            S_RST:   return int'(pll_rst);
            S_READY: return int'(pll_ready);
            S_FAIL:  return int'(pll_fail);
            S_RETRY: return int'(retry_cnt);
            default: return int'(lock_loss_cnt);
        endcase
    endfunction

    task automatic expect_at(input int e, input int sig, input int val);
        exp_t x;
        x.at_edge = e;
        x.sig     = sig;
        x.val     = val;
        sb_q.push_back(x);
    endtask

    task automatic expect_reset_vals(input int e);
        expect_at(e, S_STATE, 0);
        expect_at(e, S_RST,   1);
        expect_at(e, S_READY, 0);
        expect_at(e, S_FAIL,  0);
        expect_at(e, S_RETRY, 0);
        expect_at(e, S_LOSS,  0);
    endtask

    // One clock edge, then retire every expectation due at that edge.
    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
        for (int i = 0; i < sb_q.size(); ) begin
            if (sb_q[i].at_edge == cyc) begin
                check_eq($sformatf("%s@e%0d", sig_name(sb_q[i].sig), cyc),
                         sig_value(sb_q[i].sig), sb_q[i].val);
                sb_q.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic run_to(input int e);
        while (cyc < e) tick();
    endtask

    // Returns the edge number of cycle 0 (first edge sampling rst_n=1).
    task automatic do_reset(output int e0);
        rst_n       = 1'b0;
        restart_req = 1'b0;
        expect_reset_vals(cyc + 2);
        expect_reset_vals(cyc + 3);
        tick();
        tick();
        tick();
        rst_n = 1'b1;
        e0    = cyc + 1;
    endtask

    initial begin
        int e0;
        int j;
        int r;
        int exp_loss;

        rst_n       = 1'b0;
        locked      = 1'b0;
        restart_req = 1'b0;
        tick();

        // Clean lock at cycle 10
        locked = 1'b0;
        do_reset(e0);
        for (int i = 0; i < 4; i++) expect_at(e0 + i, S_RST, 1);
        expect_at(e0 + 4,  S_RST,   0);
        expect_at(e0 + 4,  S_STATE, 1);
        expect_at(e0 + 12, S_STATE, 2);
        expect_at(e0 + 19, S_READY, 0);
        expect_at(e0 + 20, S_READY, 1);
        expect_at(e0 + 20, S_STATE, 3);
        expect_at(e0 + 20, S_RETRY, 0);
        run_to(e0 + 9);
        locked = 1'b1;
        run_to(e0 + 22);
        $display("tx clean_lock e0=%0d ready=%0d", e0, pll_ready);

        // No lock: three attempts, then FAIL, then restart
        locked = 1'b0;
        do_reset(e0);
        expect_at(e0 + 3,   S_RST,   1);
        expect_at(e0 + 4,   S_RST,   0);
        expect_at(e0 + 35,  S_RST,   0);
        expect_at(e0 + 36,  S_RST,   1);
        expect_at(e0 + 36,  S_RETRY, 1);
        expect_at(e0 + 39,  S_RST,   1);
        expect_at(e0 + 40,  S_RST,   0);
        expect_at(e0 + 72,  S_RST,   1);
        expect_at(e0 + 72,  S_RETRY, 2);
        expect_at(e0 + 76,  S_RST,   0);
        expect_at(e0 + 107, S_STATE, 1);
        expect_at(e0 + 107, S_FAIL,  0);
        expect_at(e0 + 108, S_STATE, 4);
        expect_at(e0 + 108, S_FAIL,  1);
        expect_at(e0 + 108, S_RST,   1);
        expect_at(e0 + 108, S_RETRY, 2);
        run_to(e0 + 110);
        restart_req = 1'b1;
        r = cyc + 1;
        expect_at(r,     S_FAIL,  1);
        expect_at(r,     S_STATE, 4);
        expect_at(r + 1, S_FAIL,  0);
        expect_at(r + 1, S_RETRY, 0);
        expect_at(r + 1, S_STATE, 0);
        expect_at(r + 1, S_RST,   1);
        tick();
        restart_req = 1'b0;
        run_to(r + 2);
        $display("tx no_lock e0=%0d restart_edge=%0d fail=%0d", e0, r, pll_fail);

        // Lock chatter: high 5, low 1, then steady
        locked = 1'b0;
        do_reset(e0);
        expect_at(e0 + 15, S_STATE, 2);
        expect_at(e0 + 16, S_STATE, 2);
        expect_at(e0 + 17, S_STATE, 1);
        expect_at(e0 + 18, S_STATE, 2);
        expect_at(e0 + 25, S_READY, 0);
        expect_at(e0 + 26, S_READY, 1);
        expect_at(e0 + 26, S_RETRY, 0);
        expect_at(e0 + 26, S_LOSS,  0);
        run_to(e0 + 9);
        locked = 1'b1;
        run_to(e0 + 14);
        locked = 1'b0;
        run_to(e0 + 15);
        locked = 1'b1;
        run_to(e0 + 27);
        $display("tx chatter e0=%0d ready=%0d", e0, pll_ready);

        // Lock loss in RUN, repeated until the counter saturates
        for (int n = 1; n <= 300; n++) begin
            exp_loss = (n > 255) ? 255 : n;
            locked = 1'b0;
            j = cyc + 1;
            expect_at(j + 1,  S_READY, 1);
            expect_at(j + 2,  S_READY, 0);
            expect_at(j + 2,  S_RST,   1);
            expect_at(j + 2,  S_STATE, 0);
            expect_at(j + 2,  S_LOSS,  exp_loss);
            expect_at(j + 15, S_READY, 1);
            expect_at(j + 15, S_STATE, 3);
            tick();
            locked = 1'b1;
            run_to(j + 15);
            $display("tx lock_loss n=%0d j=%0d loss=%0d", n, j, lock_loss_cnt);
        end

        // restart_req lands on the STABLE->RUN edge
        locked = 1'b0;
        j = cyc + 1;
        expect_at(j + 2,  S_LOSS,  255);
        expect_at(j + 14, S_STATE, 2);
        expect_at(j + 15, S_STATE, 0);
        expect_at(j + 15, S_READY, 0);
        expect_at(j + 15, S_RST,   1);
        expect_at(j + 15, S_LOSS,  255);
        expect_at(j + 16, S_READY, 0);
        expect_at(j + 27, S_READY, 0);
        expect_at(j + 28, S_READY, 1);
        tick();
        locked = 1'b1;
        run_to(j + 13);
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        run_to(j + 29);
        $display("tx restart_vs_run j=%0d ready=%0d", j, pll_ready);

        // rst_n low in the middle of WAIT_LOCK after one timeout
        locked = 1'b0;
        j = cyc + 1;
        expect_at(j + 2,  S_STATE, 0);
        expect_at(j + 6,  S_STATE, 1);
        expect_at(j + 37, S_STATE, 1);
        expect_at(j + 38, S_STATE, 0);
        expect_at(j + 38, S_RETRY, 1);
        expect_at(j + 42, S_STATE, 1);
        expect_at(j + 45, S_STATE, 1);
        expect_at(j + 45, S_RETRY, 1);
        expect_at(j + 45, S_LOSS,  255);
        expect_at(j + 45, S_RST,   0);
        expect_reset_vals(j + 46);
        run_to(j + 44);
        rst_n = 1'b0;
        run_to(j + 47);
        $display("tx reset_mid_wait j=%0d state=%0d", j, state);

        check_eq("sb_leftover", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_lock_ctrl.md
# pll_lock_ctrl

Reset and lock sequencer for the core-clock PLL. It runs on the PLL reference clock and drives the PLL `rst` input. It qualifies the PLL `locked` output, retries the PLL on lock timeout, and produces a single `pll_ready` level that gates release of the hashing-core reset. It sits beside the PLL instance at the top level. `pll_ready` is synchronized into the core clock domain by the consumer.

## Interface
- `RST_CYCLES`, 16: refclk cycles `pll_rst` is held high per reset attempt (≥2).
- `STABLE_CYCLES`, 1024: consecutive cycles of qualified lock required before `pll_ready` (≥1).
- `TIMEOUT_CYCLES`, 65536: cycles to wait for lock after each PLL reset (≥1).
- `MAX_RETRIES`, 3: timed-out attempts retried before declaring failure (0..255).
- `CNT_W`, 8: width of the status counters.

Ports:
- `refclk` in 1: the only clock (PLL reference, 25 MHz).
- `rst_n` in 1: synchronous, active-low reset.
- `locked` in 1: PLL lock, asynchronous to refclk.
- `restart_req` in 1: single-cycle request to re-sequence the PLL.
- `pll_rst` out 1: PLL reset, active-high, registered.
- `pll_ready` out 1: lock qualified, core may run; registered.
- `pll_fail` out 1: sticky failure after retries are exhausted; registered.
- `state` out 3: current FSM state encoding.
- `retry_cnt` out CNT_W: timeouts in the current sequence.
- `lock_loss_cnt` out CNT_W: lock losses while in RUN; saturating.

## Operation
- `locked` passes through a 2-flop synchronizer; the result, `lock_s`, is used everywhere. Both sync flops reset to 0.
- The FSM uses one timer. The timer clears to 0 on every state change, otherwise increments. Its width is clog2 of the largest cycle parameter, plus 1.
- States (encoding):
  - RESET=0: `pll_rst`=1. At timer==RST_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK=1:
    - If `lock_s`=1, go to STABLE.
    - Else at timer==TIMEOUT_CYCLES-1: if retry_cnt==MAX_RETRIES, go to FAIL; otherwise increment retry_cnt and go to RESET.
  - STABLE=2:
    - If `lock_s`=0, go to WAIT_LOCK. The timeout restarts and retry_cnt is unchanged.
    - Else at timer==STABLE_CYCLES-1, go to RUN.
  - RUN=3: `pll_ready`=1 and retry_cnt clears on entry. If `lock_s`=0, increment lock_loss_cnt (saturating at all-ones) and go to RESET.
  - FAIL=4: `pll_rst`=1 and `pll_fail`=1. Exited only by `restart_req` or `rst_n`.
- `restart_req`=1 in any state forces RESET and clears retry_cnt and the timer. It does not clear lock_loss_cnt. If asserted in RESET, it restarts the RESET count.
- Priority, highest first: `rst_n` low, then `restart_req`, then lock loss or timeout, then normal progression.
- Outputs are registered, decoded from next-state, so they change on the same edge as `state`. No combinational path exists from inputs to outputs.
- `lock_loss_cnt` counts only in RUN. A lock drop in STABLE is not a loss.

## Timing
- While `rst_n`=0 at an edge, the following edge produces:
  - `state`=RESET, `pll_rst`=1, `pll_ready`=0, `pll_fail`=0.
  - retry_cnt=0, lock_loss_cnt=0, timer=0, sync flops=0.
- Cycle 0 is the first edge with `rst_n`=1. `pll_rst` stays 1 through cycle RST_CYCLES-1 and is 0 from cycle RST_CYCLES onward.
- Edge k is the first edge that samples `locked`=1 in WAIT_LOCK:
  - STABLE is entered at k+2.
  - RUN and `pll_ready`=1 follow at k+2+STABLE_CYCLES.
- Edge j is the first edge that samples `locked`=0 in RUN. At j+2: `pll_ready`=0, `pll_rst`=1, lock_loss_cnt incremented.
- Timeout: `pll_rst` rises again exactly TIMEOUT_CYCLES edges after WAIT_LOCK entry.
- A `restart_req` sampled at edge r gives `pll_rst`=1 and `pll_ready`=0 at r+1.
- Worst case to FAIL, measured from cycle 0: (MAX_RETRIES+1)×(RST_CYCLES+TIMEOUT_CYCLES) edges.

## Test plan
Bench parameters: RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRIES=2.

1. Clean lock: release `rst_n`, raise `locked` at cycle 10 and hold it → `pll_rst` is 1 for cycles 0–3, `pll_ready` rises at the edge k+10, and retry_cnt=0.
2. No lock: hold `locked`=0 → `pll_rst` pulses three times, 4 cycles each, 32 cycles apart; retry_cnt reaches 2; `pll_fail`=1 and `state`=4 at edge 108. Asserting `restart_req` then clears `pll_fail` and retry_cnt.
3. Lock chatter: `locked` high for 5 cycles, low for 1, then steady → no RUN before the drop, no retry_cnt increment, `pll_ready` 10 edges after the final rise, lock_loss_cnt=0.
4. Lock loss in RUN: drop `locked` for 1 cycle → at j+2 `pll_ready`=0, `pll_rst`=1, lock_loss_cnt=1; the full sequence recovers. Repeat 300 times → lock_loss_cnt saturates at 255.
5. Simultaneous events: `restart_req` on the same edge as the STABLE→RUN transition → RESET wins and `pll_ready` stays 0. `rst_n`=0 mid-WAIT_LOCK → all outputs return to their reset values on the next edge.
